// File: rtl/sisc_multicycle_core_if.sv
// Memory port bundle for the SISC multicycle core: single req/ack transaction channel.
// The core drives req/we/addr/wdata (master); the memory returns rdata/ack (slave).
interface sisc_multicycle_core_if #(
   parameter int WIDTH    = 32,
   parameter int ADDRSIZE = 12
) ();
   logic                mem_req;
   logic                mem_we;
   logic [ADDRSIZE-1:0] mem_addr;
   logic [WIDTH-1:0]    mem_wdata;
   logic [WIDTH-1:0]    mem_rdata;
   logic                mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/sisc_multicycle_core.sv
// Multicycle SISC core: FETCH/DECODE/OPRD/EXEC/WB/HALT FSM over one req/ack memory port.
// Optional cycle/instret counters are built when SISC_PERF_CNT_EN is defined.
module sisc_multicycle_core #(
   parameter int WIDTH    = 32,
   parameter int ADDRSIZE = 12,
   parameter int NREGS    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   sisc_multicycle_core_if.master mem,
   output logic [ADDRSIZE-1:0]   pc_out,
   output logic [4:0]            psr_out,
   output logic                  halted,
   output logic                  err
`ifdef SISC_PERF_CNT_EN
   ,
   output logic [31:0]           cycle_cnt,
   output logic [31:0]           instret_cnt
`endif
);

   localparam int RIDX = $clog2(NREGS);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_OPRD   = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_BRA = 4'h1;
   localparam logic [3:0] OP_LD  = 4'h2;
   localparam logic [3:0] OP_STR = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_MUL = 4'h6;
   localparam logic [3:0] OP_CMP = 4'h7;
   localparam logic [3:0] OP_SHF = 4'h8;
   localparam logic [3:0] OP_ROT = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hA;
   localparam logic [3:0] OP_MOV = 4'hB;

   logic [2:0]          state;
   logic [ADDRSIZE-1:0] pc;
   logic [31:0]         ir;
   logic [WIDTH-1:0]    mdr;
   logic [4:0]          psr;
   logic [WIDTH-1:0]    regs [NREGS];

   logic                req;
   logic                we;
   logic [ADDRSIZE-1:0] addr;
   logic [WIDTH-1:0]    wdata;

   // Instruction fields; cc overlaps srct/dstt and is only meaningful for BRA.
   logic [3:0]          op;
   logic                srct;
   logic                dstt;
   logic [3:0]          cc;
   logic [11:0]         src_f;
   logic [11:0]         dst_f;
   logic [RIDX-1:0]     src_idx;
   logic [RIDX-1:0]     dst_idx;
   logic [WIDTH-1:0]    imm;
   logic [ADDRSIZE-1:0] src_addr;
   logic [ADDRSIZE-1:0] dst_addr;

   assign op       = ir[31:28];
   assign srct     = ir[27];
   assign dstt     = ir[26];
   assign cc       = ir[27:24];
   assign src_f    = ir[23:12];
   assign dst_f    = ir[11:0];
   assign src_idx  = src_f[RIDX-1:0];
   assign dst_idx  = dst_f[RIDX-1:0];
   assign imm      = WIDTH'(src_f);
   assign src_addr = ADDRSIZE'(src_f);
   assign dst_addr = ADDRSIZE'(dst_f);

   logic is_alu;
   logic illegal;
   logic needs_mem_rd;
   logic writes_mem;
   logic writes_reg;
   logic sets_flags;

   assign is_alu       = (op >= OP_ADD) && (op <= OP_ROT);
   assign illegal      = (op > OP_MOV);
   assign needs_mem_rd = ((op == OP_LD) && !srct) || (is_alu && dstt);
   assign writes_mem   = (op == OP_STR) || (is_alu && dstt);
   assign writes_reg   = (op == OP_LD) || (op == OP_MOV) || (is_alu && !dstt);
   assign sets_flags   = (op == OP_LD) || (op == OP_STR) || (op == OP_MOV) || is_alu;

   // Execute datapath
   logic [WIDTH-1:0]   opa;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;
   logic               kneg;
   logic [12:0]        k13;
   logic [12:0]        kmag;
   int                 rot_amt;
   logic [2*WIDTH-1:0] rot_r;
   logic [2*WIDTH-1:0] rot_l;
   logic [WIDTH-1:0]   result;
   logic               carry;
   logic [4:0]         new_psr;
   logic               br_taken;
   logic [ADDRSIZE-1:0] next_pc;

   // NOTE: every always_comb output is given a default first so no path can infer a latch.
   always_comb begin
      opa      = srct ? imm : regs[src_idx];
      opb      = dstt ? mdr : regs[dst_idx];
      sum      = {1'b0, opa} + {1'b0, opb};
      diff     = {1'b0, opa} - {1'b0, opb};
      prod     = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
      kneg     = opa[11];
      k13      = {opa[11], opa[11:0]};
      kmag     = kneg ? (~k13 + 13'd1) : k13;
      rot_amt  = int'(kmag) % WIDTH;
      rot_r    = {opb, opb} >> rot_amt;
      rot_l    = {opb, opb} << rot_amt;
      result   = '0;
      carry    = 1'b0;
      case (op)
         OP_LD:   result = srct ? imm : mdr;
         OP_STR:  result = opa;
         OP_MOV:  result = opa;
         OP_ADD:  {carry, result} = sum;
         OP_SUB:  {carry, result} = diff;
         OP_MUL: begin
            result = prod[WIDTH-1:0];
            carry  = |prod[2*WIDTH-1:WIDTH];
         end
         OP_CMP:  result = ~opa;
         OP_SHF: begin
            if (int'(kmag) >= WIDTH) result = '0;
            else if (kneg)           result = opb << kmag;
            else                     result = opb >> kmag;
         end
         OP_ROT:  result = kneg ? rot_l[2*WIDTH-1:WIDTH] : rot_r[WIDTH-1:0];
         default: result = '0;
      endcase
      new_psr = {result[WIDTH-1], (result == '0), ^result, ~result[0], carry};

      // psr = {NEG,ZERO,PARITY,EVEN,CARRY}
      case (cc)
         4'd0:    br_taken = 1'b1;
         4'd1:    br_taken = psr[0];
         4'd2:    br_taken = psr[1];
         4'd3:    br_taken = psr[2];
         4'd4:    br_taken = psr[3];
         4'd5:    br_taken = psr[4];
         default: br_taken = 1'b0;
      endcase
      next_pc = ((op == OP_BRA) && br_taken) ? dst_addr : pc;
   end

   // NOTE: the register file is cleared on reset together with the rest of the state,
   // so it is built from flops rather than an uninitialised RAM.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= S_FETCH;
         pc     <= '0;
         psr    <= '0;
         ir     <= '0;
         mdr    <= '0;
         req    <= 1'b0;
         we     <= 1'b0;
         addr   <= '0;
         wdata  <= '0;
         halted <= 1'b0;
         err    <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
         case (state)
            S_FETCH: begin
               if (!req) begin
                  // Entered with no request pending (after reset or a write-back).
                  req  <= 1'b1;
                  we   <= 1'b0;
                  addr <= pc;
               end else if (mem.mem_ack) begin
                  req   <= 1'b0;
                  ir    <= mem.mem_rdata[31:0];
                  pc    <= pc + ADDRSIZE'(1);
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (needs_mem_rd) begin
                  req   <= 1'b1;
                  we    <= 1'b0;
                  addr  <= (op == OP_LD) ? src_addr : dst_addr;
                  state <= S_OPRD;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_OPRD: begin
               if (mem.mem_ack) begin
                  req   <= 1'b0;
                  mdr   <= mem.mem_rdata;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (sets_flags) psr <= new_psr;
               if (writes_reg) regs[dst_idx] <= result;
               if ((op == OP_HLT) || illegal) begin
                  halted <= 1'b1;
                  err    <= illegal;
                  state  <= S_HALT;
               end else if (writes_mem) begin
                  req   <= 1'b1;
                  we    <= 1'b1;
                  addr  <= dst_addr;
                  wdata <= result;
                  state <= S_WB;
               end else begin
                  // Issue the next fetch directly so a register op costs three cycles.
                  pc    <= next_pc;
                  req   <= 1'b1;
                  we    <= 1'b0;
                  addr  <= next_pc;
                  state <= S_FETCH;
               end
            end
            S_WB: begin
               if (mem.mem_ack) begin
                  req   <= 1'b0;
                  we    <= 1'b0;
                  state <= S_FETCH;
               end
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_HALT;
         endcase
      end
   end

   assign mem.mem_req   = req;
   assign mem.mem_we    = we;
   assign mem.mem_addr  = addr;
   assign mem.mem_wdata = wdata;
   assign pc_out        = pc;
   assign psr_out       = psr;

`ifdef SISC_PERF_CNT_EN
   logic retire;

   // HLT retires in EXEC; memory-writing instructions retire when the write is acknowledged.
   assign retire = ((state == S_EXEC) && !illegal && !writes_mem) ||
                   ((state == S_WB) && mem.mem_ack);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (!halted) cycle_cnt   <= cycle_cnt + 32'd1;
         if (retire)  instret_cnt <= instret_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sisc_multicycle_core.sv
// Self-checking bench for sisc_multicycle_core: behavioural memory with wait/hold control
// and a scoreboard of expected memory writes and psr values at specific fetch addresses.
module tb_sisc_multicycle_core;

   localparam int WIDTH    = 32;
   localparam int ADDRSIZE = 12;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LD  = 4'h2;
   localparam logic [3:0] OP_STR = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_MUL = 4'h6;
   localparam logic [3:0] OP_CMP = 4'h7;
   localparam logic [3:0] OP_SHF = 4'h8;
   localparam logic [3:0] OP_ROT = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hA;
   localparam logic [3:0] OP_MOV = 4'hB;

   typedef struct {
      bit          is_psr;
      logic [11:0] addr;
      logic [31:0] data;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset;
   logic [ADDRSIZE-1:0] pc_out;
   logic [4:0]          psr_out;
   logic                halted;
   logic                err;
`ifdef SISC_PERF_CNT_EN
   logic [31:0]         cycle_cnt;
   logic [31:0]         instret_cnt;
`endif

   sisc_multicycle_core_if #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) m ();

   sisc_multicycle_core #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .NREGS(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .mem     (m),
      .pc_out  (pc_out),
      .psr_out (psr_out),
      .halted  (halted),
      .err     (err)
`ifdef SISC_PERF_CNT_EN
      ,
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sb[$];
   logic [31:0] mem_arr [4096];

   bit          hold_en   = 1'b0;
   logic [11:0] hold_addr = '0;
   bit          wait_en   = 1'b0;
   logic [11:0] wait_addr = '0;
   int          wait_n    = 0;
   int          wcnt      = 0;
   int          cyc       = 0;
   int          last_cyc  = 0;
   bit          stable    = 1'b1;
   bit          last_stable = 1'b1;
   bit          in_txn    = 1'b0;
   logic [11:0] start_addr = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] psr_of(input logic [31:0] r, input logic c);
      return {r[31], (r == 32'd0), ^r, ~r[0], c};
   endfunction

   function automatic logic [31:0] enc(input logic [3:0] op, input logic s, input logic d,
                                       input logic [11:0] src, input logic [11:0] dst);
      return {op, s, d, 2'b00, src, dst};
   endfunction

   function automatic logic [31:0] bra(input logic [3:0] cc, input logic [11:0] dst);
      return {4'h1, cc, 12'h000, dst};
   endfunction

   task automatic push_psr(input logic [11:0] fetch_addr, input logic [4:0] p);
      exp_t e;
      e.is_psr = 1'b1; e.addr = fetch_addr; e.data = {27'd0, p};
      sb.push_back(e);
   endtask

   task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
      exp_t e;
      e.is_psr = 1'b0; e.addr = a; e.data = d;
      sb.push_back(e);
   endtask

   task automatic sb_write(input logic [11:0] a, input logic [31:0] d);
      exp_t e;
      if (sb.size() == 0) begin
         check("wr_unexpected", 64'(a), 64'hFFFF);
      end else begin
         e = sb.pop_front();
         check("wr_kind", 64'(e.is_psr), 64'd0);
         check("wr_addr", 64'(a), 64'(e.addr));
         check("wr_data", 64'(d), 64'(e.data));
      end
   endtask

   task automatic sb_fetch(input logic [11:0] a);
      if (sb.size() > 0 && sb[0].is_psr && sb[0].addr == a) begin
         check($sformatf("psr_at_%0h", a), 64'(psr_out), 64'(sb[0].data));
         void'(sb.pop_front());
      end
   endtask

   // Behavioural memory: acks on the negedge so the core samples it on the next posedge.
   always @(negedge clk) begin
      if (m.mem_ack) begin
         m.mem_ack = 1'b0;
      end else if (!m.mem_req) begin
         in_txn = 1'b0;
         wcnt   = 0;
      end else begin
         if (!in_txn) begin
            in_txn     = 1'b1;
            start_addr = m.mem_addr;
            cyc        = 0;
            stable     = 1'b1;
            wcnt       = 0;
         end
         cyc++;
         if (m.mem_addr !== start_addr) stable = 1'b0;
         if (!(hold_en && !m.mem_we && m.mem_addr == hold_addr)) begin
            if (wait_en && !m.mem_we && m.mem_addr == wait_addr && wcnt < wait_n) begin
               wcnt++;
            end else begin
               m.mem_ack   = 1'b1;
               in_txn      = 1'b0;
               last_cyc    = cyc;
               last_stable = stable;
               if (m.mem_we) begin
                  mem_arr[m.mem_addr] = m.mem_wdata;
                  sb_write(m.mem_addr, m.mem_wdata);
               end else begin
                  m.mem_rdata = mem_arr[m.mem_addr];
                  sb_fetch(m.mem_addr);
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_req_at(input logic [11:0] a, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (m.mem_req && m.mem_addr == a) found = 1'b1;
      end
      check(tag, 64'(found), 64'd1);
   endtask

   task automatic wait_ack(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (m.mem_ack) found = 1'b1;
      end
      check(tag, 64'(found), 64'd1);
   endtask

   task automatic wait_halt(input string tag);
      for (int i = 0; i < 2000 && !halted; i++) step();
      check(tag, 64'(halted), 64'd1);
   endtask

   task automatic count_idle_req(input string tag);
      int n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (m.mem_req) n++;
      end
      check(tag, 64'(n), 64'd0);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem_arr[i] = enc(OP_NOP, 1'b0, 1'b0, 12'h0, 12'h0);
   endtask

   initial begin
      reset       = 1'b0;
      m.mem_ack   = 1'b0;
      m.mem_rdata = '0;
      clear_mem();

      // Reset during a stalled fetch, then a fetch with three wait cycles.
      mem_arr[0] = enc(OP_MOV, 1'b1, 1'b0, 12'd1, 12'd1);
      mem_arr[1] = enc(OP_HLT, 1'b0, 1'b0, 12'd0, 12'd0);
      repeat (3) step();
      hold_en   = 1'b1;
      hold_addr = 12'h001;
      reset     = 1'b1;
      wait_req_at(12'h001, "reach_held_fetch");
      check("pre_rst_pc", 64'(pc_out), 64'd1);
      check("pre_rst_psr", 64'(psr_out), 64'(psr_of(32'd1, 1'b0)));
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_req", 64'(m.mem_req), 64'd0);
         check("rst_pc", 64'(pc_out), 64'd0);
         check("rst_psr", 64'(psr_out), 64'd0);
      end
      check("rst_halted", 64'(halted), 64'd0);
      hold_en   = 1'b0;
      wait_en   = 1'b1;
      wait_addr = 12'h000;
      wait_n    = 3;
      reset     = 1'b1;
      wait_req_at(12'h000, "first_fetch_addr0");
      wait_ack("wait_fetch_ack");
      check("pc_before_ack", 64'(pc_out), 64'd0);
      check("req_cycles", 64'(last_cyc), 64'd4);
      check("addr_stable", 64'(last_stable), 64'd1);
      step();
      check("pc_after_ack", 64'(pc_out), 64'd1);
      wait_en = 1'b0;
      wait_halt("halt_prog1");
      check("prog1_err", 64'(err), 64'd0);

      // Main program: ALU ops, loads/stores, branches, memory-destination ALU ops.
      reset = 1'b0;
      repeat (2) step();
      clear_mem();
      mem_arr[12'h000] = enc(OP_MOV, 1'b1, 1'b0, 12'd5, 12'd1);
      mem_arr[12'h001] = enc(OP_MOV, 1'b1, 1'b0, 12'd3, 12'd2);
      mem_arr[12'h002] = enc(OP_ADD, 1'b0, 1'b0, 12'd2, 12'd1);
      mem_arr[12'h003] = enc(OP_STR, 1'b0, 1'b0, 12'd1, 12'h100);
      mem_arr[12'h004] = enc(OP_MOV, 1'b1, 1'b0, 12'd3, 12'd1);
      mem_arr[12'h005] = enc(OP_MOV, 1'b1, 1'b0, 12'd5, 12'd2);
      mem_arr[12'h006] = enc(OP_SUB, 1'b0, 1'b0, 12'd1, 12'd2);
      mem_arr[12'h007] = enc(OP_STR, 1'b0, 1'b0, 12'd2, 12'h101);
      mem_arr[12'h008] = enc(OP_LD,  1'b0, 1'b0, 12'h200, 12'd3);
      mem_arr[12'h009] = enc(OP_ROT, 1'b1, 1'b0, 12'hFFF, 12'd3);
      mem_arr[12'h00A] = enc(OP_STR, 1'b0, 1'b0, 12'd3, 12'h102);
      mem_arr[12'h00B] = enc(OP_SHF, 1'b1, 1'b0, 12'd40, 12'd3);
      mem_arr[12'h00C] = bra(4'd4, 12'h020);
      mem_arr[12'h00D] = enc(OP_STR, 1'b0, 1'b0, 12'd3, 12'h1FF);
      mem_arr[12'h020] = enc(OP_ADD, 1'b1, 1'b1, 12'd7, 12'h103);
      mem_arr[12'h021] = enc(OP_MUL, 1'b1, 1'b1, 12'h100, 12'h104);
      mem_arr[12'h022] = enc(OP_CMP, 1'b1, 1'b0, 12'd0, 12'd5);
      mem_arr[12'h023] = enc(OP_STR, 1'b0, 1'b0, 12'd5, 12'h105);
      mem_arr[12'h024] = bra(4'd4, 12'h030);
      mem_arr[12'h025] = enc(OP_STR, 1'b1, 1'b0, 12'hABC, 12'h106);
      mem_arr[12'h026] = enc(OP_NOP, 1'b0, 1'b0, 12'd0, 12'd0);
      mem_arr[12'h027] = enc(OP_HLT, 1'b0, 1'b0, 12'd0, 12'd0);
      mem_arr[12'h030] = enc(OP_STR, 1'b0, 1'b0, 12'd3, 12'h1FE);
      mem_arr[12'h103] = 32'hFFFF_FFFC;
      mem_arr[12'h104] = 32'h0100_0001;
      mem_arr[12'h200] = 32'h8000_0001;

      push_psr(12'h003, psr_of(32'd8, 1'b0));
      push_wr (12'h100, 32'd8);
      push_psr(12'h007, psr_of(32'hFFFF_FFFE, 1'b1));
      push_wr (12'h101, 32'hFFFF_FFFE);
      push_psr(12'h009, psr_of(32'h8000_0001, 1'b0));
      push_psr(12'h00A, psr_of(32'h0000_0003, 1'b0));
      push_wr (12'h102, 32'h0000_0003);
      push_psr(12'h00C, psr_of(32'd0, 1'b0));
      push_psr(12'h020, psr_of(32'd0, 1'b0));
      push_wr (12'h103, 32'h0000_0003);
      push_psr(12'h021, psr_of(32'h0000_0003, 1'b1));
      push_wr (12'h104, 32'h0000_0100);
      push_psr(12'h022, psr_of(32'h0000_0100, 1'b1));
      push_psr(12'h023, psr_of(32'hFFFF_FFFF, 1'b0));
      push_wr (12'h105, 32'hFFFF_FFFF);
      push_psr(12'h025, psr_of(32'hFFFF_FFFF, 1'b0));
      push_wr (12'h106, 32'h0000_0ABC);
      push_psr(12'h026, psr_of(32'h0000_0ABC, 1'b0));

      reset = 1'b1;
      wait_halt("halt_main");
      check("main_err", 64'(err), 64'd0);
      check("main_pc", 64'(pc_out), 64'h028);
      count_idle_req("main_req_after_halt");
      check("sb_drained", 64'(sb.size()), 64'd0);

      // Illegal opcode halts with err set.
      reset = 1'b0;
      repeat (2) step();
      check("rst2_halted", 64'(halted), 64'd0);
      clear_mem();
      mem_arr[0] = 32'hF000_0000;
      reset = 1'b1;
      wait_halt("halt_illegal");
      check("illegal_err", 64'(err), 64'd1);
      check("illegal_pc", 64'(pc_out), 64'd1);
      count_idle_req("illegal_req_after_halt");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
